// File: rtl/muxn_pkg.sv
// muxn_pkg -- shared types and helpers for the muxn_pipe slice.
//   muxn_state_e    : occupancy of the two-entry output buffer (EMPTY/HALF/FULL)
//   muxn_sel_width(): width of the select bus for a given input count,
//                     never less than one bit
package muxn_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,  // no word held
    HALF  = 2'd1,  // OUT holds a word
    FULL  = 2'd2   // OUT and SKID both hold words
  } muxn_state_e;

  function automatic int muxn_sel_width(input int num_in);
    return (num_in <= 2) ? 1 : $clog2(num_in);
  endfunction

endpackage

// File: rtl/muxn_comb.sv
// muxn_comb -- combinational N:1 word selector.
// Ports:
//   in_data  : NUM_IN packed words, word k at [k*DATA_WIDTH +: DATA_WIDTH]
//   sel      : word index
//   out_data : selected word, all zeros when sel >= NUM_IN
module muxn_comb
  import muxn_pkg::*;
#(
  parameter int  DATA_WIDTH = 32,
  parameter int  NUM_IN     = 3,
  localparam int SEL_WIDTH  = muxn_sel_width(NUM_IN)
) (
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
  input  logic [SEL_WIDTH-1:0]         sel,
  output logic [DATA_WIDTH-1:0]        out_data
);

  // Zero default covers out-of-range indices, so the output is never X.
  always_comb begin
    out_data = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (int'(sel) == k) out_data = in_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: rtl/muxn_pipe.sv
// muxn_pipe -- registered N:1 multiplexer with a two-entry skid buffer.
// Optional feature macro: MUXN_PIPE_SELERR_EN (adds the sticky sel_err output).
// Ports:
//   clk, rstn  : clock (rising edge) and asynchronous active-low reset
//   in_data    : NUM_IN packed words; sel picks one of them on accept
//   in_valid / in_ready   : upstream handshake
//   out_data / out_valid / out_ready : downstream handshake
//   dbg_state  : current buffer occupancy state
//   sel_err    : (macro only) set after accepting an out-of-range sel, sticky
//
// Handshake: a word transfers on a rising edge where valid && ready are both
// high; valid never depends on ready, and in_ready comes straight from a
// flop so out_ready has no combinational path to in_ready.
module muxn_pipe
  import muxn_pkg::*;
#(
  parameter int  DATA_WIDTH = 32,
  parameter int  NUM_IN     = 3,
  localparam int SEL_WIDTH  = muxn_sel_width(NUM_IN)
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
  input  logic [SEL_WIDTH-1:0]         sel,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output muxn_state_e                  dbg_state
`ifdef MUXN_PIPE_SELERR_EN
  ,
  output logic                         sel_err
`endif
);

  muxn_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] out_q, skid_q, sel_word;
  logic                  in_ready_q;
  logic                  accept, consume;
  logic                  load_out, load_skid, skid_to_out;

  muxn_comb #(
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_IN    (NUM_IN)
  ) u_comb (
    .in_data (in_data),
    .sel     (sel),
    .out_data(sel_word)
  );

  assign accept  = in_valid && in_ready_q;
  assign consume = (state_q != EMPTY) && out_ready;

  always_comb begin
    state_d     = state_q;
    load_out    = 1'b0;
    load_skid   = 1'b0;
    skid_to_out = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          load_out = 1'b1;
          state_d  = HALF;
        end
      end
      HALF: begin
        if (accept && consume) begin
          load_out = 1'b1;
        end else if (accept) begin
          load_skid = 1'b1;
          state_d   = FULL;
        end else if (consume) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only a consume can happen.
        if (consume) begin
          skid_to_out = 1'b1;
          state_d     = HALF;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      out_q      <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      // Registered copy of (state != FULL), computed one cycle early.
      in_ready_q <= (state_d != FULL);
      if (load_out)         out_q <= sel_word;
      else if (skid_to_out) out_q <= skid_q;
      if (load_skid) skid_q <= sel_word;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = out_q;
  assign dbg_state = state_q;

`ifdef MUXN_PIPE_SELERR_EN
  logic sel_err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sel_err_q <= 1'b0;
    end else if (accept && (int'(sel) >= NUM_IN)) begin
      sel_err_q <= 1'b1;
    end
  end

  assign sel_err = sel_err_q;
`endif

endmodule

// File: tb/tb_muxn_pipe.sv
// tb_muxn_pipe -- self-checking bench for muxn_pipe.
// Two instances: a 3-input/32-bit one for directed and table-driven cases,
// and a 16-input/8-bit one for a long random valid/ready run.
// Inputs change 1 time unit after the rising edge; outputs and handshakes
// are sampled on the falling edge.
module tb_muxn_pipe;

  localparam int DW3  = 32;
  localparam int N3   = 3;
  localparam int DW16 = 8;
  localparam int N16  = 16;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- DUT signals ----------------
  logic [N3*DW3-1:0]   d3_in_data;
  logic [1:0]          d3_sel;
  logic                d3_in_valid, d3_in_ready, d3_out_valid, d3_out_ready;
  logic [DW3-1:0]      d3_out_data;
  logic [1:0]          d3_state;
  logic [N16*DW16-1:0] d16_in_data;
  logic [3:0]          d16_sel;
  logic                d16_in_valid, d16_in_ready, d16_out_valid, d16_out_ready;
  logic [DW16-1:0]     d16_out_data;
  logic [1:0]          d16_state;
`ifdef MUXN_PIPE_SELERR_EN
  logic                d3_sel_err, d16_sel_err;
`endif

  muxn_pipe #(.DATA_WIDTH(DW3), .NUM_IN(N3)) u_dut3 (
    .clk(clk), .rstn(rstn), .in_data(d3_in_data), .sel(d3_sel),
    .in_valid(d3_in_valid), .in_ready(d3_in_ready), .out_data(d3_out_data),
    .out_valid(d3_out_valid), .out_ready(d3_out_ready), .dbg_state(d3_state)
`ifdef MUXN_PIPE_SELERR_EN
    , .sel_err(d3_sel_err)
`endif
  );

  muxn_pipe #(.DATA_WIDTH(DW16), .NUM_IN(N16)) u_dut16 (
    .clk(clk), .rstn(rstn), .in_data(d16_in_data), .sel(d16_sel),
    .in_valid(d16_in_valid), .in_ready(d16_in_ready), .out_data(d16_out_data),
    .out_valid(d16_out_valid), .out_ready(d16_out_ready), .dbg_state(d16_state)
`ifdef MUXN_PIPE_SELERR_EN
    , .sel_err(d16_sel_err)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [DW3-1:0]  exp_q3[$];
  logic [DW16-1:0] exp_q16[$];
  logic [DW3-1:0]  cur_exp3;
  logic [DW16-1:0] cur_exp16;
  int acc16 = 0;
  int out16 = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (d3_out_valid && d3_out_ready) begin
        if (exp_q3.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL m3_extra: got %0h expected no word", d3_out_data);
        end else begin
          check("m3_data", d3_out_data, exp_q3.pop_front());
        end
      end
      if (d3_in_valid && d3_in_ready) exp_q3.push_back(cur_exp3);
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      if (d16_out_valid && d16_out_ready) begin
        out16++;
        if (exp_q16.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL m16_extra: got %0h expected no word", d16_out_data);
        end else begin
          check("m16_data", d16_out_data, exp_q16.pop_front());
        end
      end
      if (d16_in_valid && d16_in_ready) begin
        acc16++;
        exp_q16.push_back(cur_exp16);
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] a, b, c;
    logic [1:0]  sel;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[8];

  localparam logic [95:0] ABC = {32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
  localparam logic [95:0] BP  = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    logic fire;
    d3_in_data = '0; d3_sel = '0; d3_in_valid = 1'b0; d3_out_ready = 1'b0;
    d16_in_data = '0; d16_sel = '0; d16_in_valid = 1'b0; d16_out_ready = 1'b0;
    cur_exp3 = '0; cur_exp16 = '0;

    for (int i = 0; i < 8; i++) begin
      tbl[i].a   = 32'hA000_0000 + i;
      tbl[i].b   = 32'hB000_0000 + i;
      tbl[i].c   = 32'hC000_0000 + i;
      tbl[i].sel = 2'(i % 3);
      tbl[i].exp = (i % 3 == 0) ? tbl[i].a : (i % 3 == 1) ? tbl[i].b : tbl[i].c;
    end

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", d3_in_ready, 1);
    check("rst_out_valid", d3_out_valid, 0);
    check("rst_out_data", d3_out_data, 0);
    check("rst_state", d3_state, 0);
    check("rst16_in_ready", d16_in_ready, 1);
    check("rst16_out_valid", d16_out_valid, 0);
`ifdef MUXN_PIPE_SELERR_EN
    check("rst_sel_err", d3_sel_err, 0);
`endif
    tick(); rstn = 1'b1;

    // Single word, sel=1: valid exactly one cycle after accept, for one cycle
    tick();
    d3_out_ready = 1'b1; d3_in_data = ABC; d3_sel = 2'd1; cur_exp3 = 32'hBBBB_0002;
    d3_in_valid = 1'b1;
    @(negedge clk); check("t1_pre_valid", d3_out_valid, 0);
    tick(); d3_in_valid = 1'b0;
    @(negedge clk);
    check("t1_valid", d3_out_valid, 1);
    check("t1_data", d3_out_data, 32'hBBBB_0002);
    tick(); @(negedge clk); check("t1_valid_drop", d3_out_valid, 0);

    // Table-driven stream, sel cycling 0,1,2, one word per cycle
    tick();
    for (int i = 0; i < 8; i++) begin
      d3_in_data = {tbl[i].c, tbl[i].b, tbl[i].a};
      d3_sel = tbl[i].sel; cur_exp3 = tbl[i].exp; d3_in_valid = 1'b1;
      @(negedge clk);
      check("tbl_ready", d3_in_ready, 1);
      if (i > 0) begin
        check("tbl_stream_valid", d3_out_valid, 1);
        check("tbl_data", d3_out_data, tbl[i-1].exp);
      end
      tick();
    end
    d3_in_valid = 1'b0;
    @(negedge clk);
    check("tbl_last_valid", d3_out_valid, 1);
    check("tbl_last_data", d3_out_data, tbl[7].exp);
    tick(); @(negedge clk); check("tbl_drained", d3_out_valid, 0);

    // Backpressure: 3 words offered, 2 accepted, then drained in order
    tick();
    d3_out_ready = 1'b0; d3_in_data = BP; d3_sel = 2'd0; cur_exp3 = 32'h1111_1111;
    d3_in_valid = 1'b1;
    @(negedge clk); check("bp_rdy0", d3_in_ready, 1);
    tick(); d3_sel = 2'd1; cur_exp3 = 32'h2222_2222;
    @(negedge clk);
    check("bp_rdy1", d3_in_ready, 1);
    check("bp_out1", d3_out_data, 32'h1111_1111);
    tick(); d3_sel = 2'd2; cur_exp3 = 32'h3333_3333;
    @(negedge clk);
    check("bp_rdy_low", d3_in_ready, 0);
    check("bp_full", d3_state, 2);
    tick(); @(negedge clk);
    check("bp_hold_rdy", d3_in_ready, 0);
    check("bp_hold_data", d3_out_data, 32'h1111_1111);
    tick(); d3_out_ready = 1'b1;
    @(negedge clk); check("bp_still_low", d3_in_ready, 0);
    tick(); @(negedge clk);
    check("bp_reopen", d3_in_ready, 1);
    check("bp_out2", d3_out_data, 32'h2222_2222);
    tick(); d3_in_valid = 1'b0;
    @(negedge clk); check("bp_out3", d3_out_data, 32'h3333_3333);
    tick(); @(negedge clk);
    check("bp_empty", d3_out_valid, 0);
    check("bp_q_empty", exp_q3.size(), 0);

    // Out-of-range sel gives zero data; sel_err sticky when present
    tick();
    d3_in_data = ABC; d3_sel = 2'd3; cur_exp3 = '0; d3_in_valid = 1'b1;
    @(negedge clk);
`ifdef MUXN_PIPE_SELERR_EN
    check("se_before", d3_sel_err, 0);
`endif
    tick(); d3_sel = 2'd0; cur_exp3 = 32'hAAAA_0001;
    @(negedge clk);
    check("se_zero", d3_out_data, 0);
`ifdef MUXN_PIPE_SELERR_EN
    check("se_set", d3_sel_err, 1);
`endif
    tick(); d3_in_valid = 1'b0;
    @(negedge clk);
    check("se_legal_data", d3_out_data, 32'hAAAA_0001);
`ifdef MUXN_PIPE_SELERR_EN
    check("se_sticky", d3_sel_err, 1);
`endif
    tick(); @(negedge clk);
`ifdef MUXN_PIPE_SELERR_EN
    check("se_sticky2", d3_sel_err, 1);
`endif

    // Asynchronous reset while FULL
    tick();
    d3_out_ready = 1'b0; d3_in_data = BP; d3_sel = 2'd0; cur_exp3 = 32'h1111_1111;
    d3_in_valid = 1'b1;
    tick(); d3_sel = 2'd1; cur_exp3 = 32'h2222_2222;
    tick(); d3_in_valid = 1'b0;
    @(negedge clk);
    check("ar_pre_full", d3_state, 2);
    check("ar_pre_valid", d3_out_valid, 1);
    #2; rstn = 1'b0; exp_q3.delete();
    #1;
    check("ar_valid", d3_out_valid, 0);
    check("ar_ready", d3_in_ready, 1);
    check("ar_data", d3_out_data, 0);
    check("ar_state", d3_state, 0);
`ifdef MUXN_PIPE_SELERR_EN
    check("ar_sel_err", d3_sel_err, 0);
`endif
    tick(); rstn = 1'b1; d3_out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); check("ar_no_stale", d3_out_valid, 0);
    end
    tick();
    d3_in_data = ABC; d3_sel = 2'd2; cur_exp3 = 32'hCCCC_0003; d3_in_valid = 1'b1;
    tick(); d3_in_valid = 1'b0;
    @(negedge clk);
    check("ar_first_valid", d3_out_valid, 1);
    check("ar_first_data", d3_out_data, 32'hCCCC_0003);
    tick(); @(negedge clk); check("ar_first_drop", d3_out_valid, 0);

    // Random valid/ready on the 16-input instance
    tick();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      fire = d16_in_valid && d16_in_ready;
      tick();
      if (fire || !d16_in_valid) begin
        if ($urandom_range(0, 3) != 0) begin
          d16_in_data = {$urandom, $urandom, $urandom, $urandom};
          d16_sel = 4'($urandom_range(0, 15));
          cur_exp16 = d16_in_data[int'(d16_sel)*8 +: 8];
          d16_in_valid = 1'b1;
        end else begin
          d16_in_valid = 1'b0;
        end
      end
      d16_out_ready = ($urandom_range(0, 3) != 0);
    end
    d16_in_valid = 1'b0; d16_out_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("r16_q_empty", exp_q16.size(), 0);
    check("r16_count", out16, acc16);
    check("r16_idle", d16_out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
